// File: rtl/ifu_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ifu_inst_queue
// Description : Dual-lane fetch-to-decode instruction queue (circular buffer).
//               Optional same-cycle forwarding on an empty queue: IQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_inst_queue #(
    parameter int              DEPTH = 8,
    parameter int              DW    = 32,
    parameter int              AW    = 32,
    parameter logic [DW-1:0]   NOP   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push1_valid_i,
    input  logic [DW-1:0]            push1_inst_i,
    input  logic [AW-1:0]            push1_addr_i,
    input  logic                     push1_pred_i,
    input  logic                     push2_valid_i,
    input  logic [DW-1:0]            push2_inst_i,
    input  logic [AW-1:0]            push2_addr_i,
    input  logic                     push2_pred_i,
    output logic                     push_ready_o,
    input  logic                     stall1_i,
    input  logic                     stall2_i,
    output logic [DW-1:0]            inst1_o,
    output logic [AW-1:0]            inst1_addr_o,
    output logic                     inst1_pred_o,
    output logic                     inst1_valid_o,
    output logic [DW-1:0]            inst2_o,
    output logic [AW-1:0]            inst2_addr_o,
    output logic                     inst2_pred_o,
    output logic                     inst2_valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DW-1:0]      r_inst_mem [DEPTH];
    logic [AW-1:0]      r_addr_mem [DEPTH];
    logic               r_pred_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push_ready;
    logic               w_push1;
    logic               w_push2;
    logic [1:0]         w_push_n;
    logic [1:0]         w_pop_n;
    logic [1:0]         w_skip;
    logic [1:0]         w_wr_n;
    logic [1:0]         w_rd_adv;
    logic               w_bypass;
    logic               w_v1;
    logic               w_v2;
    logic [DW-1:0]      w_inst1;
    logic [AW-1:0]      w_addr1;
    logic               w_pred1;
    logic [DW-1:0]      w_inst2;
    logic [AW-1:0]      w_addr2;
    logic               w_pred2;
    logic [DW-1:0]      w_wr_inst;
    logic [AW-1:0]      w_wr_addr;
    logic               w_wr_pred;
    logic [c_PTR_W-1:0] w_rd_ptr1;
    logic [c_PTR_W-1:0] w_wr_ptr1;

`ifdef IQ_BYPASS_EN
    assign w_bypass = (r_count == '0) & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_rd_ptr1 = r_rd_ptr + c_PTR_W'(1);
    assign w_wr_ptr1 = r_wr_ptr + c_PTR_W'(1);

    always_comb begin
        w_push_ready = (r_count <= c_CNT_W'(DEPTH - 2));
        w_push1      = push1_valid_i & w_push_ready & ~flush_i;
        w_push2      = w_push1 & push2_valid_i;
        w_push_n     = {1'b0, w_push1} + {1'b0, w_push2};

        // On an empty queue with forwarding, the push lanes stand in for head/head+1
        if (w_bypass) begin
            w_v1    = w_push1;
            w_v2    = w_push2;
            w_inst1 = push1_inst_i;
            w_addr1 = push1_addr_i;
            w_pred1 = push1_pred_i;
            w_inst2 = push2_inst_i;
            w_addr2 = push2_addr_i;
            w_pred2 = push2_pred_i;
        end else begin
            w_v1    = (r_count != '0) & ~flush_i;
            w_v2    = (r_count >= c_CNT_W'(2)) & ~flush_i;
            w_inst1 = r_inst_mem[r_rd_ptr];
            w_addr1 = r_addr_mem[r_rd_ptr];
            w_pred1 = r_pred_mem[r_rd_ptr];
            w_inst2 = r_inst_mem[w_rd_ptr1];
            w_addr2 = r_addr_mem[w_rd_ptr1];
            w_pred2 = r_pred_mem[w_rd_ptr1];
        end

        w_pop_n  = (flush_i | stall1_i) ? 2'd0
                 : ({1'b0, w_v1} + {1'b0, w_v2 & ~stall2_i});
        // Forwarded entries consumed this cycle never touch storage
        w_skip   = w_bypass ? w_pop_n : 2'd0;
        w_wr_n   = w_push_n - w_skip;
        w_rd_adv = w_pop_n - w_skip;

        w_wr_inst = (w_skip == 2'd0) ? push1_inst_i : push2_inst_i;
        w_wr_addr = (w_skip == 2'd0) ? push1_addr_i : push2_addr_i;
        w_wr_pred = (w_skip == 2'd0) ? push1_pred_i : push2_pred_i;
    end

    assign push_ready_o  = w_push_ready;
    assign count_o       = r_count;
    assign inst1_valid_o = w_v1;
    assign inst1_o       = w_v1 ? w_inst1 : NOP;
    assign inst1_addr_o  = w_v1 ? w_addr1 : '0;
    assign inst1_pred_o  = w_v1 & w_pred1;
    assign inst2_valid_o = w_v2;
    assign inst2_o       = w_v2 ? w_inst2 : NOP;
    assign inst2_addr_o  = w_v2 ? w_addr2 : '0;
    assign inst2_pred_o  = w_v2 & w_pred2;

    always_ff @(posedge clk) begin
        if (w_wr_n != 2'd0) begin
            r_inst_mem[r_wr_ptr] <= w_wr_inst;
            r_addr_mem[r_wr_ptr] <= w_wr_addr;
            r_pred_mem[r_wr_ptr] <= w_wr_pred;
        end
        if (w_wr_n == 2'd2) begin
            r_inst_mem[w_wr_ptr1] <= push2_inst_i;
            r_addr_mem[w_wr_ptr1] <= push2_addr_i;
            r_pred_mem[w_wr_ptr1] <= push2_pred_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_rd_adv);
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_wr_n);
            r_count  <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop_n);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push1_valid_i && !w_push_ready && !flush_i))
                else $error("push while queue not ready");
            assert (!(push2_valid_i && !push1_valid_i))
                else $error("lane-2 push without lane-1 push");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ifu_inst_queue
// Description : Directed + random bench for ifu_inst_queue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_inst_queue;

    localparam int          DEPTH = 8;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IQ_BYPASS_EN
    localparam bit          BYP   = 1'b1;
`else
    localparam bit          BYP   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          push1_valid_i, push1_pred_i, push2_valid_i, push2_pred_i;
    logic [DW-1:0] push1_inst_i, push2_inst_i;
    logic [AW-1:0] push1_addr_i, push2_addr_i;
    logic          push_ready_o;
    logic          stall1_i, stall2_i;
    logic [DW-1:0] inst1_o, inst2_o;
    logic [AW-1:0] inst1_addr_o, inst2_addr_o;
    logic          inst1_pred_o, inst1_valid_o, inst2_pred_o, inst2_valid_o;
    logic [3:0]    count_o;

    ifu_inst_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .push1_valid_i(push1_valid_i), .push1_inst_i(push1_inst_i),
        .push1_addr_i(push1_addr_i), .push1_pred_i(push1_pred_i),
        .push2_valid_i(push2_valid_i), .push2_inst_i(push2_inst_i),
        .push2_addr_i(push2_addr_i), .push2_pred_i(push2_pred_i),
        .push_ready_o(push_ready_o), .stall1_i(stall1_i), .stall2_i(stall2_i),
        .inst1_o(inst1_o), .inst1_addr_o(inst1_addr_o),
        .inst1_pred_o(inst1_pred_o), .inst1_valid_o(inst1_valid_o),
        .inst2_o(inst2_o), .inst2_addr_o(inst2_addr_o),
        .inst2_pred_o(inst2_pred_o), .inst2_valid_o(inst2_valid_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] pc          = 32'h100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs, advance the model, pass the posedge
    task automatic step(input bit p1, input bit p2, input bit s1, input bit s2, input bit fl);
        ent_t pl[$];
        ent_t vis[$];
        ent_t e;
        bit   ev1, ev2, byp;
        int   n;
        if (DEPTH - q.size() < 2) begin
            p1 = 1'b0;
            p2 = 1'b0;
        end
        if (!p1) p2 = 1'b0;
        @(negedge clk);
        flush_i       = fl;
        stall1_i      = s1;
        stall2_i      = s2;
        push1_valid_i = p1;
        push2_valid_i = p2;
        push1_inst_i  = $urandom;
        push2_inst_i  = $urandom;
        push1_pred_i  = 1'($urandom_range(0, 1));
        push2_pred_i  = 1'($urandom_range(0, 1));
        push1_addr_i  = pc;
        push2_addr_i  = pc + 32'd4;
        if (p1) begin
            e.inst = push1_inst_i; e.addr = push1_addr_i; e.pred = push1_pred_i;
            if (!fl) pl.push_back(e);
            pc += 32'd4;
        end
        if (p2) begin
            e.inst = push2_inst_i; e.addr = push2_addr_i; e.pred = push2_pred_i;
            if (!fl) pl.push_back(e);
            pc += 32'd4;
        end
        #1;
        byp = BYP && (q.size() == 0) && !fl;
        vis = byp ? pl : q;
        ev1 = !fl && (vis.size() >= 1);
        ev2 = !fl && (vis.size() >= 2);
        chk("count", 64'(count_o), 64'(q.size()));
        chk("push_ready", 64'(push_ready_o), 64'((DEPTH - q.size()) >= 2));
        chk("inst1_valid", 64'(inst1_valid_o), 64'(ev1));
        chk("inst2_valid", 64'(inst2_valid_o), 64'(ev2));
        if (ev1) begin
            chk("inst1", 64'(inst1_o), 64'(vis[0].inst));
            chk("inst1_addr", 64'(inst1_addr_o), 64'(vis[0].addr));
            chk("inst1_pred", 64'(inst1_pred_o), 64'(vis[0].pred));
        end else begin
            chk("inst1_nop", 64'(inst1_o), 64'(NOP));
            chk("inst1_addr0", 64'(inst1_addr_o), 64'd0);
            chk("inst1_pred0", 64'(inst1_pred_o), 64'd0);
        end
        if (ev2) begin
            chk("inst2", 64'(inst2_o), 64'(vis[1].inst));
            chk("inst2_addr", 64'(inst2_addr_o), 64'(vis[1].addr));
            chk("inst2_pred", 64'(inst2_pred_o), 64'(vis[1].pred));
        end else begin
            chk("inst2_nop", 64'(inst2_o), 64'(NOP));
            chk("inst2_addr0", 64'(inst2_addr_o), 64'd0);
            chk("inst2_pred0", 64'(inst2_pred_o), 64'd0);
        end
        n = (fl || s1) ? 0 : (int'(ev1) + int'(ev2 && !s2));
        if (fl) begin
            q.delete();
        end else if (byp) begin
            q = pl;
            repeat (n) void'(q.pop_front());
        end else begin
            repeat (n) void'(q.pop_front());
            foreach (pl[i]) q.push_back(pl[i]);
        end
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; stall1_i = 1'b0; stall2_i = 1'b0;
        push1_valid_i = 1'b0; push2_valid_i = 1'b0;
        push1_inst_i = '0; push2_inst_i = '0; push1_addr_i = '0; push2_addr_i = '0;
        push1_pred_i = 1'b0; push2_pred_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(push_ready_o), 64'd1);
        chk("rst_v1", 64'(inst1_valid_o), 64'd0);
        chk("rst_v2", 64'(inst2_valid_o), 64'd0);
        chk("rst_inst1", 64'(inst1_o), 64'(NOP));
        rst_n = 1'b1;

        // Two pushes, no stall
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Fill to full under lane-1 stall, then drain two per cycle
        repeat (5) step(1, 1, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);

        // Fill to 5, hold lane 2 for three cycles
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        // Steady-state streaming across the pointer wrap
        repeat (21) step(1, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        // Flush at count 6 with a simultaneous push
        repeat (3) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);

        // Empty-queue pushes (forwarded when bypass is built in)
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        repeat (300)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);

        // Asynchronous reset in the middle of a cycle
        repeat (4) step(1, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_v1", 64'(inst1_valid_o), 64'd0);
        chk("arst_ready", 64'(push_ready_o), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
